// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for the register file's single write port.
// Each source owns a one-entry buffer; grants are round-robin, with same-rd conflicts resolved by age.
module regfile_write_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [ADDR_W-1:0]      a_rd,
    input  logic [DATA_W-1:0]      a_data,
    input  logic                   m_valid,
    output logic                   m_ready,
    input  logic [ADDR_W-1:0]      m_rd,
    input  logic [DATA_W-1:0]      m_data,
    output logic                   RegWrite,
    output logic [ADDR_W-1:0]      RD,
    output logic [DATA_W-1:0]      WriteData,
    output logic [(1<<ADDR_W)-1:0] pending_mask,
    output logic                   busy
);

    logic              a_vld_p0;
    logic              m_vld_p0;
    logic [ADDR_W-1:0] a_rd_p0;
    logic [ADDR_W-1:0] m_rd_p0;
    logic [DATA_W-1:0] a_data_p0;
    logic [DATA_W-1:0] m_data_p0;
    logic              last_m;
    logic              m_older;

    logic a_cap;
    logic m_cap;
    logic pick_m;
    logic grant_a;
    logic grant_m;
    logic a_hold;
    logic m_hold;

    assign a_ready = !a_vld_p0;
    assign m_ready = !m_vld_p0;
    assign a_cap   = a_valid && !a_vld_p0;
    assign m_cap   = m_valid && !m_vld_p0;
    assign busy    = a_vld_p0 || m_vld_p0;

    always_comb begin
        pick_m = 1'b0;
        if (a_rd_p0 == m_rd_p0) begin
            pick_m = m_older;
        end else begin
            pick_m = !last_m;
        end
    end

    assign grant_m = m_vld_p0 && (!a_vld_p0 || pick_m);
    assign grant_a = a_vld_p0 && !grant_m;
    // Buffers still occupied after this edge; decides which capture is the younger one.
    assign a_hold  = a_vld_p0 && !grant_a;
    assign m_hold  = m_vld_p0 && !grant_m;

    always_comb begin
        pending_mask = '0;
        if (a_vld_p0 && (a_rd_p0 != '0)) pending_mask[a_rd_p0] = 1'b1;
        if (m_vld_p0 && (m_rd_p0 != '0)) pending_mask[m_rd_p0] = 1'b1;
    end

    // Stage p0: input buffers (payload is not reset; only valid qualifies it)
    always_ff @(posedge clk) begin
        if (a_cap) begin
            a_rd_p0   <= a_rd;
            a_data_p0 <= a_data;
        end
        if (m_cap) begin
            m_rd_p0   <= m_rd;
            m_data_p0 <= m_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld_p0 <= 1'b0;
            m_vld_p0 <= 1'b0;
            last_m   <= 1'b1;
            m_older  <= 1'b0;
        end else begin
            if (a_cap) begin
                a_vld_p0 <= 1'b1;
            end else if (grant_a) begin
                a_vld_p0 <= 1'b0;
            end
            if (m_cap) begin
                m_vld_p0 <= 1'b1;
            end else if (grant_m) begin
                m_vld_p0 <= 1'b0;
            end
            if (grant_m) begin
                last_m <= 1'b1;
            end else if (grant_a) begin
                last_m <= 1'b0;
            end
            if (m_cap && (a_cap || !a_hold)) begin
                m_older <= 1'b1;
            end else if (a_cap && !m_hold) begin
                m_older <= 1'b0;
            end
        end
    end

    // Stage p1: registered register-file write port
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
        end else if (grant_m) begin
            RegWrite  <= (m_rd_p0 != '0);
            RD        <= m_rd_p0;
            WriteData <= m_data_p0;
        end else if (grant_a) begin
            RegWrite  <= (a_rd_p0 != '0);
            RD        <= a_rd_p0;
            WriteData <= a_data_p0;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

endmodule
